flappy_game_ctrl: RTL and testbench

Game sequencer for the Flappy Bird design. It runs the round state machine (idle, play, dying, game over), integrates the bird's vertical physics once per frame, and keeps the BCD score. It sits between the clock divider's per-frame tick, the debounced flap button and the pipe/collision logic on one side, and the VGA renderer and 7-segment display on the other.

---
 rtl/flappy_game_ctrl_if.sv | 24 ++
 rtl/flappy_game_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_flappy_game_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/flappy_game_ctrl_if.sv
// rtl/flappy_game_ctrl_if.sv - game sequencer event inputs and display/scroll outputs
interface flappy_game_ctrl_if;
    logic        frame_tick;
    logic        btn_flap;
    logic        collide;
    logic        pipe_pass;
    logic [1:0]  state;
    logic [9:0]  bird_y;
    logic        run;
    logic [15:0] score_bcd;
    logic        game_over;

    // Event source side: tick divider, button, pipe/collision logic
    modport master (
        output frame_tick, btn_flap, collide, pipe_pass,
        input  state, bird_y, run, score_bcd, game_over
    );

    // Sequencer side
    modport slave (
        input  frame_tick, btn_flap, collide, pipe_pass,
        output state, bird_y, run, score_bcd, game_over
    );
endinterface

// File: rtl/flappy_game_ctrl.sv
// rtl/flappy_game_ctrl.sv - round FSM, per-frame bird physics and BCD score
module flappy_game_ctrl #(
    parameter int Y_START      = 232,
    parameter int Y_TOP        = 0,
    parameter int Y_FLOOR      = 440,
    parameter int GRAVITY      = 1,
    parameter int FLAP_VEL     = -8,
    parameter int VMAX         = 8,
    parameter int DEATH_FRAMES = 60
) (
    input  logic             clk,
    input  logic             clr,
    flappy_game_ctrl_if.slave io
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_DYING = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    localparam int CW = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES + 1) : 1;

    localparam logic [9:0]         YSTART_U = 10'(Y_START);
    localparam logic [9:0]         YTOP_U   = 10'(Y_TOP);
    localparam logic [9:0]         YFLOOR_U = 10'(Y_FLOOR);
    localparam logic signed [10:0] YTOP_S   = 11'(Y_TOP);
    localparam logic signed [10:0] YFLOOR_S = 11'(Y_FLOOR);
    localparam logic signed [5:0]  FLAP_V   = 6'(FLAP_VEL);
    localparam logic signed [5:0]  VMAX_V   = 6'(VMAX);
    localparam logic signed [6:0]  VMAX7    = 7'(VMAX);
    localparam logic signed [6:0]  GRAV7    = 7'(GRAVITY);
    localparam logic [CW-1:0]      CNT_LAST = CW'(DEATH_FRAMES - 1);

    state_t             state_q, state_d;
    logic [9:0]         y_q, y_d;
    logic signed [5:0]  vel_q, vel_d;
    logic [15:0]        score_q, score_d;
    logic               pend_q, pend_d;
    logic               btn_q;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic               flap_edge;
    logic               pend_eff;
    logic signed [10:0] y_n;
    logic signed [6:0]  vel_sum;
    logic signed [5:0]  vel_fall;
    logic [9:0]         y_clamp;

    // Saturating 4-digit BCD increment; 9999 stays 9999
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        if (v != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (c) begin
                    if (r[4*i +: 4] == 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    // Physics helpers: next position from current velocity, gravity step, range clamp
    always_comb begin
        flap_edge = io.btn_flap & ~btn_q;
        pend_eff  = pend_q | flap_edge;
        y_n       = $signed({1'b0, y_q}) + $signed({{5{vel_q[5]}}, vel_q});
        vel_sum   = $signed({vel_q[5], vel_q}) + GRAV7;
        vel_fall  = (vel_sum > VMAX7) ? VMAX_V : vel_sum[5:0];
        if (y_n < YTOP_S) begin
            y_clamp = YTOP_U;
        end else if (y_n > YFLOOR_S) begin
            y_clamp = YFLOOR_U;
        end else begin
            y_clamp = y_n[9:0];
        end
    end

    // Next-state and next-datapath decode; moves happen only on frame_tick
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        vel_d   = vel_q;
        score_d = score_q;
        pend_d  = pend_eff;
        cnt_d   = cnt_q;

        if (io.pipe_pass && state_q == S_PLAY) begin
            score_d = bcd_inc(score_q);
        end

        case (state_q)
            S_IDLE: begin
                y_d   = YSTART_U;
                vel_d = '0;
                if (io.frame_tick) begin
                    pend_d = 1'b0;
                    if (pend_eff) begin
                        state_d = S_PLAY;
                        vel_d   = FLAP_V;
                        score_d = '0;
                    end
                end
            end
            S_PLAY: begin
                if (io.frame_tick) begin
                    pend_d = 1'b0;
                    vel_d  = pend_eff ? FLAP_V : vel_fall;
                    // Death takes priority over the ceiling clamp
                    if (y_n >= YFLOOR_S || io.collide) begin
                        state_d = S_DYING;
                        y_d     = y_clamp;
                        cnt_d   = '0;
                        if (y_n < YTOP_S) begin
                            vel_d = '0;
                        end
                    end else if (y_n < YTOP_S) begin
                        y_d   = YTOP_U;
                        vel_d = '0;
                    end else begin
                        y_d = y_n[9:0];
                    end
                end
            end
            S_DYING: begin
                pend_d = 1'b0;
                if (io.frame_tick) begin
                    vel_d = vel_fall;
                    y_d   = y_clamp;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_OVER;
                    end
                end
            end
            S_OVER: begin
                if (io.frame_tick) begin
                    pend_d = 1'b0;
                    if (pend_eff) begin
                        state_d = S_IDLE;
                        y_d     = YSTART_U;
                        vel_d   = '0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous clear
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            y_q     <= YSTART_U;
            vel_q   <= '0;
            score_q <= '0;
            pend_q  <= 1'b0;
            btn_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            vel_q   <= vel_d;
            score_q <= score_d;
            pend_q  <= pend_d;
            btn_q   <= io.btn_flap;
            cnt_q   <= cnt_d;
        end
    end

    assign io.state     = state_q;
    assign io.bird_y    = y_q;
    assign io.run       = (state_q == S_PLAY);
    assign io.game_over = (state_q == S_OVER);
    assign io.score_bcd = score_q;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// tb/tb_flappy_game_ctrl.sv - scoreboard bench for flappy_game_ctrl
module tb_flappy_game_ctrl;

    typedef struct {
        string       name;
        logic [1:0]  st;
        logic [9:0]  y;
        logic [15:0] sc;
    } exp_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    logic chk_req = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];

    flappy_game_ctrl_if io();

    flappy_game_ctrl dut (
        .clk (clk),
        .clr (clr),
        .io  (io)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input string fld, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, fld, act, req);
        end
    endtask

    // Monitor: after every flagged edge, pop the expected response and compare
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (chk_req) begin
                #1;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL scoreboard: output presented with empty expect queue");
                end else begin
                    e = exp_q.pop_front();
                    cmp(e.name, "state",     int'(io.state),     int'(e.st));
                    cmp(e.name, "bird_y",    int'(io.bird_y),    int'(e.y));
                    cmp(e.name, "score",     int'(io.score_bcd), int'(e.sc));
                    cmp(e.name, "run",       int'(io.run),       (e.st == 2'd1) ? 1 : 0);
                    cmp(e.name, "game_over", int'(io.game_over), (e.st == 2'd3) ? 1 : 0);
                end
            end
        end
    end

    // One active cycle followed by one quiet cycle
    task automatic drive(input logic ft, input logic fl, input logic co, input logic pp,
                         input logic cl, input bit chk, input string nm,
                         input logic [1:0] st, input logic [9:0] y, input logic [15:0] sc);
        exp_t e;
        @(negedge clk);
        io.frame_tick = ft;
        io.btn_flap   = fl;
        io.collide    = co;
        io.pipe_pass  = pp;
        clr           = cl;
        chk_req       = chk;
        if (chk) begin
            e.name = nm;
            e.st   = st;
            e.y    = y;
            e.sc   = sc;
            exp_q.push_back(e);
        end
        @(negedge clk);
        io.frame_tick = 1'b0;
        io.btn_flap   = 1'b0;
        io.collide    = 1'b0;
        io.pipe_pass  = 1'b0;
        clr           = 1'b0;
        chk_req       = 1'b0;
    endtask

    task automatic tk(input logic fl, input logic co, input logic pp, input bit chk,
                      input string nm, input logic [1:0] st, input logic [9:0] y,
                      input logic [15:0] sc);
        drive(1'b1, fl, co, pp, 1'b0, chk, nm, st, y, sc);
    endtask

    task automatic pulse(input bit chk, input string nm, input logic [1:0] st,
                         input logic [9:0] y, input logic [15:0] sc);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, chk, nm, st, y, sc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        io.frame_tick = 1'b0;
        io.btn_flap   = 1'b0;
        io.collide    = 1'b0;
        io.pipe_pass  = 1'b0;
        repeat (3) @(negedge clk);

        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, "reset", 2'd0, 10'd232, 16'h0000);

        // Round start and first falls
        tk(1, 0, 0, 1, "start", 2'd1, 10'd232, 16'h0000);
        tk(0, 0, 0, 1, "fall1", 2'd1, 10'd224, 16'h0000);
        tk(0, 0, 0, 1, "fall2", 2'd1, 10'd217, 16'h0000);

        // Decimal carry
        repeat (98) pulse(0, "", 2'd0, 10'd0, 16'h0);
        pulse(1, "bcd99",  2'd1, 10'd217, 16'h0099);
        pulse(1, "bcd100", 2'd1, 10'd217, 16'h0100);
        pulse(1, "bcd101", 2'd1, 10'd217, 16'h0101);

        // Free fall to the floor
        for (int i = 5; i <= 43; i++) tk(0, 0, 0, 0, "", 2'd0, 10'd0, 16'h0);
        tk(0, 0, 0, 1, "pre_floor", 2'd1, 10'd432, 16'h0101);
        tk(0, 0, 0, 1, "floor",     2'd2, 10'd440, 16'h0101);

        // Dying window, flaps ignored
        for (int i = 1; i <= 58; i++) tk(1, 0, 0, 0, "", 2'd0, 10'd0, 16'h0);
        tk(0, 0, 0, 1, "dying59", 2'd2, 10'd440, 16'h0101);
        tk(0, 0, 0, 1, "over",    2'd3, 10'd440, 16'h0101);

        // Game over hold and exit
        tk(0, 0, 0, 1, "over_hold", 2'd3, 10'd440, 16'h0101);
        pulse(1, "over_pass", 2'd3, 10'd440, 16'h0101);
        tk(1, 0, 0, 1, "over_exit", 2'd0, 10'd232, 16'h0101);
        tk(1, 0, 0, 1, "restart",   2'd1, 10'd232, 16'h0000);

        // Collide with simultaneous pipe pass
        tk(0, 1, 1, 1, "collide",    2'd2, 10'd224, 16'h0001);
        tk(1, 0, 0, 1, "dying_flap", 2'd2, 10'd217, 16'h0001);
        tk(0, 0, 0, 1, "dying_fall", 2'd2, 10'd211, 16'h0001);
        pulse(1, "dying_pass", 2'd2, 10'd211, 16'h0001);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, "clr1", 2'd0, 10'd232, 16'h0000);

        // Climb to y=100 with score 42, then clear mid-round
        tk(1, 0, 0, 1, "h_start", 2'd1, 10'd232, 16'h0000);
        repeat (42) pulse(0, "", 2'd0, 10'd0, 16'h0);
        for (int i = 0; i < 7; i++)  tk(0, 0, 0, 0, "", 2'd0, 10'd0, 16'h0);
        for (int i = 0; i < 12; i++) tk(1, 0, 0, 0, "", 2'd0, 10'd0, 16'h0);
        tk(1, 0, 0, 1, "h_y100", 2'd1, 10'd100, 16'h0042);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, "", 2'd0, 10'd0, 16'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, "clr_mid", 2'd0, 10'd232, 16'h0000);
        tk(0, 0, 0, 1, "no_start", 2'd0, 10'd232, 16'h0000);

        // Clear together with a tick
        tk(1, 0, 0, 1, "s2", 2'd1, 10'd232, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, "clr_tick", 2'd0, 10'd232, 16'h0000);

        // Ceiling clamp overrides a flap
        tk(1, 0, 0, 1, "s3", 2'd1, 10'd232, 16'h0000);
        for (int i = 1; i <= 28; i++) tk(1, 0, 0, 0, "", 2'd0, 10'd0, 16'h0);
        tk(1, 0, 0, 1, "top_exact", 2'd1, 10'd0, 16'h0000);
        tk(1, 0, 0, 1, "top_clamp", 2'd1, 10'd0, 16'h0000);
        tk(0, 0, 0, 1, "top_hold",  2'd1, 10'd0, 16'h0000);
        tk(0, 0, 0, 1, "top_fall",  2'd1, 10'd1, 16'h0000);

        // Score saturation
        repeat (9998) pulse(0, "", 2'd0, 10'd0, 16'h0);
        pulse(1, "sat_9999", 2'd1, 10'd1, 16'h9999);
        pulse(1, "sat_hold", 2'd1, 10'd1, 16'h9999);

        repeat (3) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected responses never checked, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
